// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg
// Shared definitions for the MEM-stage access sequencer:
//   - trunk_mode encodings (access size and extension)
//   - FSM state enum of the MEM sequencer
//   - access-size decode helpers
// ============================================================================
package mips_pkg;

    localparam logic [2:0] TM_WORD   = 3'd0;
    localparam logic [2:0] TM_HALF_U = 3'd1;
    localparam logic [2:0] TM_HALF_S = 3'd2;
    localparam logic [2:0] TM_BYTE_U = 3'd3;
    localparam logic [2:0] TM_BYTE_S = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } access_size_t;

    // Encodings 5-7 are not defined and fall back to a plain word access.
    function automatic access_size_t decode_size(input logic [2:0] tm);
        case (tm)
            TM_HALF_U, TM_HALF_S: decode_size = SZ_HALF;
            TM_BYTE_U, TM_BYTE_S: decode_size = SZ_BYTE;
            default:              decode_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic is_signed_mode(input logic [2:0] tm);
        is_signed_mode = (tm == TM_HALF_S) || (tm == TM_BYTE_S);
    endfunction

endpackage

// File: rtl/load_store_align.sv
// ============================================================================
// load_store_align
// Purely combinational lane logic for the MEM stage (little-endian: byte n
// lives in bits [8n+7:8n]).
// Ports:
//   trunk_mode  in  3   access size / extension
//   addr_lo     in  2   byte address bits [1:0]
//   is_store    in  1   selects store byte enables (loads always use 4'b1111)
//   wdata       in  32  raw store data
//   rdata       in  32  raw memory read data
//   be          out 4   byte enables
//   wdata_lane  out 32  store data replicated onto the lanes
//   load_value  out 32  selected and sign/zero extended load data
//   misalign    out 1   access not aligned to its size
// ============================================================================
module load_store_align
    import mips_pkg::*;
(
    input  logic [2:0]  trunk_mode,
    input  logic [1:0]  addr_lo,
    input  logic        is_store,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_value,
    output logic        misalign
);

    access_size_t size;
    logic         sign_ext;
    logic [3:0]   byte_onehot;
    logic [7:0]   rbyte [4];
    logic [7:0]   sel_byte;
    logic [15:0]  sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_onehot[gi] = (addr_lo == 2'(gi));
            assign rbyte[gi]       = rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        size       = decode_size(trunk_mode);
        sign_ext   = is_signed_mode(trunk_mode);
        sel_byte   = rbyte[addr_lo];
        sel_half   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        be         = 4'b1111;
        wdata_lane = wdata;
        load_value = rdata;
        misalign   = 1'b0;

        case (size)
            SZ_HALF: begin
                misalign   = addr_lo[0];
                load_value = {{16{sign_ext & sel_half[15]}}, sel_half};
                wdata_lane = {2{wdata[15:0]}};
                if (is_store) begin
                    be = addr_lo[1] ? 4'b1100 : 4'b0011;
                end
            end
            SZ_BYTE: begin
                load_value = {{24{sign_ext & sel_byte[7]}}, sel_byte};
                wdata_lane = {4{wdata[7:0]}};
                if (is_store) begin
                    be = byte_onehot;
                end
            end
            default: begin
                misalign = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl
// MEM-stage sequencer: runs one data-memory transaction per load/store over a
// variable-latency req/ack port and stalls the upstream pipeline meanwhile.
// Optional feature macro: MEM_TIMEOUT_EN (abort a WAIT after TIMEOUT_CYCLES
// cycles without mem_ack; without it, timeout is constant 0).
// Ports:
//   clock, reset                   clock / synchronous active-high reset
//   MemRead_in, MemWrite_in        load / store request (store wins)
//   trunk_mode_in [2:0]            access size and extension
//   addr_in, wdata_in [31:0]       byte address / store data
//   stall                          comb: freeze upstream pipeline registers
//   load_data [31:0]               extended load result, held until next load
//   misalign                       comb: misaligned op in IDLE, not issued
//   timeout                        one-cycle pulse on an aborted access
//   mem_req, mem_we, mem_addr,
//   mem_be, mem_wdata              registered memory request
//   mem_rdata, mem_ack             memory response (ack sampled only in WAIT)
// ============================================================================
module mem_access_ctrl
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [2:0]  trunk_mode_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    mem_state_t  state_reg, state_next;

    logic        mem_req_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [3:0]  mem_be_reg;
    logic [31:0] mem_wdata_reg;
    logic [31:0] load_data_reg;
    logic        is_load_reg;
    logic [2:0]  mode_reg;
    logic [1:0]  addr_lo_reg;

    logic        op_present;
    logic        start;
    logic        abort;
    logic [2:0]  align_mode;
    logic [1:0]  align_addr_lo;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] load_c;
    logic        mis_c;

    // In IDLE the lane logic looks at the live EX/MEM inputs; once an access
    // is in flight it uses the captured mode/offset so load extraction does
    // not depend on the upstream registers staying frozen.
    always_comb begin
        align_mode    = trunk_mode_in;
        align_addr_lo = addr_in[1:0];
        if (state_reg != ST_IDLE) begin
            align_mode    = mode_reg;
            align_addr_lo = addr_lo_reg;
        end
    end

    load_store_align u_align (
        .trunk_mode (align_mode),
        .addr_lo    (align_addr_lo),
        .is_store   (MemWrite_in),
        .wdata      (wdata_in),
        .rdata      (mem_rdata),
        .be         (be_c),
        .wdata_lane (wdata_c),
        .load_value (load_c),
        .misalign   (mis_c)
    );

    assign op_present = MemRead_in | MemWrite_in;
    assign start      = (state_reg == ST_IDLE) && op_present && !mis_c;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_reg;
    logic             timeout_reg;

    // The counter holds the number of ack-less WAIT cycles already seen, so
    // the abort fires on the cycle that would bring it to TIMEOUT_CYCLES.
    assign abort = (state_reg == ST_WAIT) && !mem_ack &&
                   (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= abort;
            if (start) begin
                cnt_reg <= '0;
            end else if ((state_reg == ST_WAIT) && !mem_ack) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign timeout = timeout_reg;
`else
    assign abort   = 1'b0;
    // TIMEOUT_CYCLES has no effect without the counter; this folds to 0.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_WAIT;
            ST_WAIT: if (mem_ack || abort) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        stall    = start || (state_reg == ST_WAIT);
        misalign = (state_reg == ST_IDLE) && op_present && mis_c;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_be_reg    <= '0;
            mem_wdata_reg <= '0;
            load_data_reg <= '0;
            is_load_reg   <= 1'b0;
            mode_reg      <= TM_WORD;
            addr_lo_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= MemWrite_in;
                        mem_addr_reg  <= {addr_in[31:2], 2'b00};
                        mem_be_reg    <= be_c;
                        mem_wdata_reg <= wdata_c;
                        is_load_reg   <= !MemWrite_in;
                        mode_reg      <= trunk_mode_in;
                        addr_lo_reg   <= addr_in[1:0];
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        mem_req_reg <= 1'b0;
                        if (is_load_reg) load_data_reg <= load_c;
                    end else if (abort) begin
                        mem_req_reg <= 1'b0;
                        if (is_load_reg) load_data_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_be    = mem_be_reg;
    assign mem_wdata = mem_wdata_reg;
    assign load_data = load_data_reg;

endmodule
